// File: rtl/mmio_timer_resp.sv
// Memory-mapped prescaled 32-bit timer with compare-match, auto-reload and interrupt.
// Responds to core load/store strobes with a one-cycle registered read path.
module mmio_timer_resp #(
  parameter logic [31:0] BASE    = 32'h0000_1000,
  parameter int unsigned PRESC_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] data,
  input  logic [1:0]  mask,
  input  logic        wrt_en,
  input  logic        rd_en,
  output logic [31:0] data_out,
  output logic        rd_valid,
  output logic        irq
);

  localparam logic [2:0] OffCtrl   = 3'd0;
  localparam logic [2:0] OffPresc  = 3'd1;
  localparam logic [2:0] OffCount  = 3'd2;
  localparam logic [2:0] OffCmp    = 3'd3;
  localparam logic [2:0] OffStatus = 3'd4;

  logic [2:0]         ctrl_q, ctrl_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [31:0]        count_q, count_d;
  logic [31:0]        cmp_q, cmp_d;
  logic               match_q, match_d;
  logic               err_q, err_d;
  logic [31:0]        data_out_q, data_out_d;
  logic               rd_valid_q, rd_valid_d;
  logic               irq_q, irq_d;

  logic [2:0]  offset;
  logic        hit;
  logic        misaligned;
  logic        wr_ok;
  logic        wr_err;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] bmask;
  logic [31:0] rdata;
  logic        tick;
  logic        cmp_hit;
  logic [1:0]  w1c;

  assign offset = address[4:2];
  assign hit    = (address[31:5] == BASE[31:5]) && (offset <= 3'd4);

  always_comb begin
    misaligned = 1'b0;
    be         = 4'b0000;
    wdata      = '0;
    unique case (mask)
      2'b00: begin
        be    = 4'b0001 << address[1:0];
        wdata = {4{data[7:0]}};
      end
      2'b01: begin
        misaligned = address[0];
        be         = address[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{data[15:0]}};
      end
      2'b10: begin
        misaligned = (address[1:0] != 2'b00);
        be         = 4'b1111;
        wdata      = data;
      end
      default: misaligned = 1'b1;
    endcase
  end

  assign bmask  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign wr_ok  = wrt_en && hit && !misaligned;
  assign wr_err = wrt_en && hit && misaligned;
  assign w1c    = wdata[1:0] & bmask[1:0];

  always_comb begin
    rdata = '0;
    unique case (offset)
      OffCtrl:   rdata = 32'(ctrl_q);
      OffPresc:  rdata = 32'(presc_q);
      OffCount:  rdata = count_q;
      OffCmp:    rdata = cmp_q;
      OffStatus: rdata = {30'd0, err_q, match_q};
      default:   rdata = '0;
    endcase
  end

  // Compare always uses the pre-write COUNT/CMP so a colliding store cannot hide a match.
  assign tick    = ctrl_q[0] && (pcnt_q == presc_q);
  assign cmp_hit = tick && (count_q == cmp_q);

  always_comb begin
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    match_d = match_q;
    err_d   = err_q;

    if (ctrl_q[0]) begin
      pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
    end
    if (tick) begin
      count_d = (cmp_hit && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;
    end

    if (wr_ok) begin
      unique case (offset)
        OffCtrl:   ctrl_d  = (ctrl_q & ~bmask[2:0]) | (wdata[2:0] & bmask[2:0]);
        OffPresc: begin
          presc_d = (presc_q & ~bmask[PRESC_W-1:0]) | (wdata[PRESC_W-1:0] & bmask[PRESC_W-1:0]);
          pcnt_d  = '0;
        end
        OffCount:  count_d = (count_q & ~bmask) | (wdata & bmask);
        OffCmp:    cmp_d   = (cmp_q & ~bmask) | (wdata & bmask);
        OffStatus: begin
          if (w1c[0]) match_d = 1'b0;
          if (w1c[1]) err_d   = 1'b0;
        end
        default: ;
      endcase
    end

    // Hardware set beats a same-cycle software clear.
    if (cmp_hit) match_d = 1'b1;
    if (wr_err)  err_d   = 1'b1;
  end

  assign irq_d      = match_d & ctrl_d[2];
  assign rd_valid_d = rd_en && hit;
  assign data_out_d = rd_valid_d ? rdata : data_out_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q     <= '0;
      presc_q    <= '0;
      pcnt_q     <= '0;
      count_q    <= '0;
      cmp_q      <= '0;
      match_q    <= 1'b0;
      err_q      <= 1'b0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
      count_q    <= count_d;
      cmp_q      <= cmp_d;
      match_q    <= match_d;
      err_q      <= err_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      irq_q      <= irq_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign irq      = irq_q;

endmodule

// File: doc/mmio_timer_resp.md
Name: mmio_timer_resp

Overview:
- Memory-mapped responder on the core's data-side load/store interface (address, data, mask, wrt_en, rd_en).
- Sits beside data_mem and claims a small address window at BASE.
- Implements a prescaled 32-bit up-counter with compare-match, optional auto-reload and an interrupt output.
- Load/store instructions issued by the RV32I core are the initiator; this block is the responding end.

Parameters:
- BASE, 32'h0000_1000, byte address of register 0; window is BASE..BASE+0x13, word-aligned.
- PRESC_W, 16, width of the prescale register and prescale counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- address  in  32  byte address from ALU result.
- data  in  32  store data (rs2), lane-0 aligned as produced by the core.
- mask  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved (access ignored).
- wrt_en  in  1  store strobe, one cycle per store.
- rd_en  in  1  load strobe, one cycle per load.
- data_out  out  32  registered read data, full aligned word.
- rd_valid  out  1  one-cycle pulse qualifying data_out.
- irq  out  1  level interrupt = STATUS.match & CTRL.ie.

Behaviour:
- Hit = address[31:5] == BASE[31:5] and address[4:2] <= 3'd4; offset = address[4:2].
- Registers:
  - 0 CTRL[2:0]: en, autoreload, ie.
  - 1 PRESC[PRESC_W-1:0].
  - 2 COUNT[31:0].
  - 3 CMP[31:0].
  - 4 STATUS[0] match (write-1-to-clear); STATUS[1] err (sticky, write-1-to-clear).
  - Unimplemented bits read 0.
- Reset (rst==0 at a clock edge): all registers 0, prescale counter 0, data_out 0, rd_valid 0, irq 0. Reset mid-count discards any pending tick. A reset coinciding with an access drops the access.
- Write (wrt_en & hit):
  - Word: whole register.
  - Halfword: lanes selected by address[1]; data[15:0] is placed there.
  - Byte: lane selected by address[1:0]; data[7:0] is placed there.
  - Misaligned access (half with address[0]=1, word with address[1:0]!=0) or mask 11: register unchanged, STATUS.err set.
  - Takes effect at the clock edge; visible to a read issued the next cycle.
- Read (rd_en & hit): data_out <= aligned register word on the edge, rd_valid=1 for exactly that following cycle. Latency 1. Lane extraction and sign extension belong to the initiator.
  - No hit: rd_valid stays 0 and data_out holds its value.
  - Back-to-back reads: one response per cycle.
- Simultaneous rd_en and wrt_en to the same register: read returns the old value.
- Prescaler:
  - While CTRL.en=1, pcnt increments every cycle.
  - When pcnt==PRESC, a tick is asserted and pcnt <= 0. PRESC=0 gives a tick every cycle.
  - CTRL.en=0 freezes both pcnt and COUNT.
  - A write to PRESC also clears pcnt.
- Tick:
  - If COUNT==CMP (pre-increment value): STATUS.match <= 1, and COUNT <= 0 if autoreload=1, else COUNT+1.
  - Otherwise COUNT <= COUNT+1, wrapping 0xFFFFFFFF -> 0 with no flag.
- Collisions:
  - Software write to COUNT in the same cycle as a tick: software value wins; the compare still uses the pre-write value.
  - Write-1-to-clear of match in the same cycle a new match is set: set wins.
- irq is registered from the next-state values of match and ie, so it rises in the same cycle STATUS.match reads 1.

Test Plan:
- Reset: drive rst=0 for 2 cycles with random strobes -> rd_valid=0, irq=0; subsequent reads of all 5 offsets return 0.
- Word write then read: write 0xDEADBEEF to CMP (BASE+0xC); next cycle rd_en -> one cycle later data_out=0xDEADBEEF with a single rd_valid pulse. A read of BASE+0x20 gives no rd_valid.
- Sub-word writes: byte 0xAA to BASE+0xE, then half 0x1234 to BASE+0xC -> CMP=0x00AA1234. Half write to BASE+0xD leaves CMP unchanged and sets STATUS.err -> STATUS reads 0x2.
- Prescale/compare: PRESC=3, CMP=2, CTRL=0b111 -> COUNT steps every 4 cycles. Match raises irq on the tick with COUNT==2, after which COUNT=0. Writing 1 to STATUS drops irq the next cycle.
- Wrap with autoreload=0: COUNT=0xFFFFFFFF, CMP=5, PRESC=0, en=1 -> COUNT=0 on the next cycle with no match; match occurs 6 cycles later and COUNT continues to 6.
- Collisions: a COUNT write coinciding with a tick -> written value stored. W1C of match coinciding with a new match -> match stays 1. Reset asserted mid-count -> COUNT=0, pcnt restarts from 0 after release.
